// File: rtl/inventory_ram.sv
// inventory_ram: dual-port inventory word store. Port A (vend engine) adds saturating DEC/INC,
// port B (MODBUS) reads/writes; optional zero-fill after reset. Optional parity: INVRAM_PARITY_EN.
module inventory_ram #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned DEPTH          = 256,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req,
  input  logic [1:0]            a_op,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_ready,
  output logic                  a_ack,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic                  a_sat,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_ack,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  b_coll,
`ifdef INVRAM_PARITY_EN
  output logic [1:0]            par_err,
`endif
  output logic                  busy
);

`ifdef INVRAM_PARITY_EN
  localparam int unsigned PAR_W = 1;
`else
  localparam int unsigned PAR_W = 0;
`endif
  localparam int unsigned MEM_W = DATA_WIDTH + PAR_W;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_DEC   = 2'b10;

  localparam logic [DATA_WIDTH-1:0] ALL_ONES  = '1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t                  state, state_d;
  logic [ADDR_WIDTH-1:0]   clr_cnt, clr_cnt_d;

  logic [MEM_W-1:0]        mem [DEPTH];

  logic                    a_in_rng, b_in_rng;
  logic [MEM_W-1:0]        a_word, b_word;
  logic [DATA_WIDTH-1:0]   a_rd, b_rd;

  logic                    a_acc, b_acc, a_rmw, a_wr, b_wr;
  logic                    a_wr_en, b_wr_en, clr_we, b_coll_c;
  logic [ADDR_WIDTH-1:0]   a_wr_addr;
  logic [DATA_WIDTH-1:0]   a_wr_data;

  logic                    rmw_fwd, rmw_sat;
  logic [DATA_WIDTH-1:0]   rmw_opnd, rmw_res;

  logic                    wb_pending, wb_valid, wb_sat;
  logic [ADDR_WIDTH-1:0]   wb_addr;
  logic [DATA_WIDTH-1:0]   wb_data;

  // Stored word encoding; the parity bit (when present) sits above the data.
  function automatic logic [MEM_W-1:0] encode(input logic [DATA_WIDTH-1:0] d);
`ifdef INVRAM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  // Asynchronous read of both ports; out-of-range addresses read as zero.
  assign a_in_rng = 32'(a_addr) < DEPTH;
  assign b_in_rng = 32'(b_addr) < DEPTH;
  assign a_word   = a_in_rng ? mem[a_addr] : '0;
  assign b_word   = b_in_rng ? mem[b_addr] : '0;
  assign a_rd     = a_word[DATA_WIDTH-1:0];
  assign b_rd     = b_word[DATA_WIDTH-1:0];

  // Request acceptance; nothing is accepted while in reset or clearing.
  assign a_acc = rst_n && !busy && a_ready && a_req;
  assign b_acc = rst_n && !busy && b_req;
  assign a_rmw = a_acc && a_op[1];
  assign a_wr  = a_acc && (a_op == OP_WRITE) && a_in_rng;
  assign b_wr  = b_acc && b_we && b_in_rng;

  // Port A owns the write slot on its write edge, whether a WRITE or a DEC/INC write-back.
  assign a_wr_en   = a_wr || (wb_pending && wb_valid);
  assign a_wr_addr = wb_pending ? wb_addr : a_addr;
  assign a_wr_data = wb_pending ? wb_data : a_wdata;
  assign b_coll_c  = b_wr && a_wr_en && (a_wr_addr == b_addr);
  assign b_wr_en   = b_wr && !b_coll_c;
  assign clr_we    = rst_n && (state == CLEAR);

  // DEC/INC operand: a port B write landing on the same edge is seen by the operation.
  assign rmw_fwd = b_wr && (b_addr == a_addr);

  always_comb begin
    rmw_opnd = rmw_fwd ? b_wdata : a_rd;
    rmw_sat  = 1'b0;
    rmw_res  = rmw_opnd;
    if (a_op == OP_DEC) begin
      if (rmw_opnd == '0) rmw_sat = 1'b1;
      else                rmw_res = rmw_opnd - DATA_WIDTH'(1);
    end else begin
      if (rmw_opnd == ALL_ONES) rmw_sat = 1'b1;
      else                      rmw_res = rmw_opnd + DATA_WIDTH'(1);
    end
    if (!a_in_rng) begin
      rmw_sat = 1'b0;
      rmw_res = '0;
    end
  end

  // Storage array: no reset, contents survive reset until the clear sequence runs.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt] <= encode('0);
    end else begin
      if (a_wr_en) mem[a_wr_addr] <= encode(a_wr_data);
      if (b_wr_en) mem[b_addr]    <= encode(b_wdata);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (CLEAR_ON_RESET) state <= CLEAR;
      else                state <= READY;
      clr_cnt <= '0;
    end else begin
      state   <= state_d;
      clr_cnt <= clr_cnt_d;
    end
  end

  // FSM next state: CLEAR walks every address once, then hands over to READY.
  always_comb begin
    state_d   = state;
    clr_cnt_d = clr_cnt;
    case (state)
      CLEAR: begin
        clr_cnt_d = clr_cnt + ADDR_WIDTH'(1);
        if (clr_cnt == LAST_ADDR) begin
          state_d   = READY;
          clr_cnt_d = '0;
        end
      end
      READY:   state_d = READY;
      default: state_d = READY;
    endcase
  end

  // Registered port responses and the DEC/INC write-back stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= CLEAR_ON_RESET;
      a_ready    <= 1'b0;
      a_ack      <= 1'b0;
      a_rdata    <= '0;
      a_sat      <= 1'b0;
      b_ack      <= 1'b0;
      b_rdata    <= '0;
      b_coll     <= 1'b0;
      wb_pending <= 1'b0;
      wb_valid   <= 1'b0;
      wb_sat     <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
    end else begin
      busy       <= (state_d == CLEAR);
      a_ready    <= (state_d == READY) && !a_rmw;
      a_ack      <= 1'b0;
      a_sat      <= 1'b0;
      b_ack      <= b_acc;
      b_coll     <= b_coll_c;
      wb_pending <= a_rmw;
      if (wb_pending) begin
        a_ack   <= 1'b1;
        a_rdata <= wb_data;
        a_sat   <= wb_sat;
      end else if (a_acc && !a_op[1]) begin
        a_ack   <= 1'b1;
        a_rdata <= a_rd;
      end
      if (a_rmw) begin
        wb_valid <= a_in_rng;
        wb_addr  <= a_addr;
        wb_data  <= rmw_res;
        wb_sat   <= rmw_sat;
      end
      if (b_acc) b_rdata <= b_rd;
    end
  end

`ifdef INVRAM_PARITY_EN
  logic wb_perr;

  // Parity flags follow the ack of the operation whose read found the bad word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err <= 2'b00;
      wb_perr <= 1'b0;
    end else begin
      par_err    <= 2'b00;
      par_err[1] <= b_acc && b_in_rng && (^b_word);
      if (wb_pending)                    par_err[0] <= wb_perr;
      else if (a_acc && !a_op[1])        par_err[0] <= a_in_rng && (^a_word);
      if (a_rmw) wb_perr <= a_in_rng && !rmw_fwd && (^a_word);
    end
  end
`endif

endmodule

// File: tb/tb_inventory_ram.sv
// tb_inventory_ram: directed bench for inventory_ram with a word-level memory model
// and a per-cycle compare process; define INVRAM_PARITY_EN to include the parity case.
module tb_inventory_ram;

  localparam logic [1:0] RD  = 2'b00;
  localparam logic [1:0] WR  = 2'b01;
  localparam logic [1:0] DEC = 2'b10;
  localparam logic [1:0] INC = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req = 1'b0;
  logic [1:0]  a_op = 2'b00;
  logic [7:0]  a_addr = 8'h00;
  logic [15:0] a_wdata = 16'h0000;
  logic        a_ready, a_ack, a_sat;
  logic [15:0] a_rdata;
  logic        b_req = 1'b0;
  logic        b_we = 1'b0;
  logic [7:0]  b_addr = 8'h00;
  logic [15:0] b_wdata = 16'h0000;
  logic        b_ack, b_coll;
  logic [15:0] b_rdata;
  logic        busy;
`ifdef INVRAM_PARITY_EN
  logic [1:0]  par_err;
`endif

  inventory_ram dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_req   (a_req),
    .a_op    (a_op),
    .a_addr  (a_addr),
    .a_wdata (a_wdata),
    .a_ready (a_ready),
    .a_ack   (a_ack),
    .a_rdata (a_rdata),
    .a_sat   (a_sat),
    .b_req   (b_req),
    .b_we    (b_we),
    .b_addr  (b_addr),
    .b_wdata (b_wdata),
    .b_ack   (b_ack),
    .b_rdata (b_rdata),
    .b_coll  (b_coll),
`ifdef INVRAM_PARITY_EN
    .par_err (par_err),
`endif
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: word contents plus what each output must show on a given cycle.
  logic [15:0] model_mem [256];
  logic [16:0] exp_a [int];
  logic [16:0] exp_b [int];
  bit          nrdy  [int];
  bit          in_rst = 1'b1;
  int          clr_end = 0;
  int          wb_issue = -1;
  logic [7:0]  wb_addr_m = 8'h00;
  logic [15:0] wb_old = 16'h0000;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void model_zero();
    for (int i = 0; i < 256; i++) model_mem[i] = 16'h0000;
    wb_issue = -1;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Issue one request per port on the coming edge and record the results the rules demand.
  task automatic drive(input bit ar, input logic [1:0] aop, input logic [7:0] aa, input logic [15:0] ad,
                       input bit br, input bit bw, input logic [7:0] ba, input logic [15:0] bd);
    int k;
    logic [15:0] a_old, b_old, opnd, res;
    bit sat, coll;
    k     = cyc;
    a_old = model_mem[aa];
    b_old = model_mem[ba];
    coll  = 1'b0;
    if (br && k == wb_issue && ba == wb_addr_m) begin
      b_old = wb_old;
      coll  = bw;
    end
    if (br && bw && ar && aop == WR && aa == ba) coll = 1'b1;
    if (br) exp_b[k+1] = {coll, b_old};
    if (br && bw && !coll) model_mem[ba] = bd;
    if (ar) begin
      case (aop)
        RD: exp_a[k+1] = {1'b0, a_old};
        WR: begin
          exp_a[k+1]    = {1'b0, a_old};
          model_mem[aa] = ad;
        end
        default: begin
          opnd = (br && bw && ba == aa) ? bd : a_old;
          if (aop == DEC) begin
            sat = (opnd == 16'h0000);
            res = sat ? 16'h0000 : opnd - 16'h0001;
          end else begin
            sat = (opnd == 16'hFFFF);
            res = sat ? 16'hFFFF : opnd + 16'h0001;
          end
          exp_a[k+2]    = {sat, res};
          nrdy[k+1]     = 1'b1;
          model_mem[aa] = res;
          wb_issue      = k + 1;
          wb_addr_m     = aa;
          wb_old        = opnd;
        end
      endcase
    end
    a_req = ar; a_op = aop; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw;  b_addr = ba; b_wdata = bd;
    @(negedge clk);
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  // Per-cycle comparison of every output against the model.
  initial begin
    logic [16:0] e;
    bit exp_busy;
    forever begin
      @(negedge clk);
      #1;
      exp_busy = in_rst || (cyc < clr_end);
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("a_ready", 32'(a_ready), 32'(!in_rst && !exp_busy && !nrdy.exists(cyc)));
      if (exp_a.exists(cyc)) begin
        e = exp_a[cyc];
        chk("a_ack", 32'(a_ack), 32'd1);
        chk("a_rdata", 32'(a_rdata), 32'(e[15:0]));
        chk("a_sat", 32'(a_sat), 32'(e[16]));
      end else begin
        chk("a_ack_idle", 32'(a_ack), 32'd0);
      end
      if (exp_b.exists(cyc)) begin
        e = exp_b[cyc];
        chk("b_ack", 32'(b_ack), 32'd1);
        chk("b_rdata", 32'(b_rdata), 32'(e[15:0]));
        chk("b_coll", 32'(b_coll), 32'(e[16]));
      end else begin
        chk("b_ack_idle", 32'(b_ack), 32'd0);
      end
      if (in_rst) begin
        chk("rst_a_rdata", 32'(a_rdata), 32'd0);
        chk("rst_b_rdata", 32'(b_rdata), 32'd0);
        chk("rst_a_sat", 32'(a_sat), 32'd0);
        chk("rst_b_coll", 32'(b_coll), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int r2;
    rst_n = 1'b0;
    in_rst = 1'b1;
    model_zero();
    idle(3);

    // Power-up clear of all 256 words.
    rst_n = 1'b1; in_rst = 1'b0; clr_end = cyc + 256;
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 1000);
    chk("busy_len", 32'(n), 32'd256);

    drive(1'b0, RD, 8'h00, 16'h0, 1'b1, 1'b0, 8'h42, 16'h0);
    chk("b_ack_42", 32'(b_ack), 32'd1);
    chk("b_rd_42", 32'(b_rdata), 32'd0);

    // DEC with two-cycle latency and a_ready low during write-back.
    drive(1'b0, RD, 8'h00, 16'h0, 1'b1, 1'b1, 8'h10, 16'h0005);
    drive(1'b1, DEC, 8'h10, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0);
    chk("dec_wb_ready", 32'(a_ready), 32'd0);
    chk("dec_wb_ack", 32'(a_ack), 32'd0);
    @(negedge clk);
    chk("dec_ack", 32'(a_ack), 32'd1);
    chk("dec_rdata", 32'(a_rdata), 32'h0004);
    chk("dec_sat", 32'(a_sat), 32'd0);

    // Saturation at both ends.
    drive(1'b1, DEC, 8'h11, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0);
    @(negedge clk);
    chk("dec0_rdata", 32'(a_rdata), 32'd0);
    chk("dec0_sat", 32'(a_sat), 32'd1);
    drive(1'b0, RD, 8'h00, 16'h0, 1'b1, 1'b0, 8'h11, 16'h0);
    chk("dec0_word", 32'(b_rdata), 32'd0);
    drive(1'b1, WR, 8'h12, 16'hFFFF, 1'b0, 1'b0, 8'h00, 16'h0);
    drive(1'b1, INC, 8'h12, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0);
    @(negedge clk);
    chk("incff_rdata", 32'(a_rdata), 32'h0000FFFF);
    chk("incff_sat", 32'(a_sat), 32'd1);
    drive(1'b1, INC, 8'h13, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0);
    idle(1);

    // Same-address write collision and B-to-DEC forwarding.
    drive(1'b1, WR, 8'h20, 16'h1111, 1'b1, 1'b1, 8'h20, 16'h2222);
    chk("coll_b_ack", 32'(b_ack), 32'd1);
    chk("coll_flag", 32'(b_coll), 32'd1);
    drive(1'b0, RD, 8'h00, 16'h0, 1'b1, 1'b0, 8'h20, 16'h0);
    chk("coll_word", 32'(b_rdata), 32'h1111);
    drive(1'b1, DEC, 8'h30, 16'h0, 1'b1, 1'b1, 8'h30, 16'h0009);
    chk("fwd_coll", 32'(b_coll), 32'd0);
    @(negedge clk);
    chk("fwd_rdata", 32'(a_rdata), 32'h0008);
    drive(1'b1, RD, 8'h30, 16'h0, 1'b1, 1'b0, 8'h30, 16'h0);
    chk("fwd_word", 32'(a_rdata), 32'h0008);

    // Cross-port reads of words being written, and disjoint simultaneous writes.
    drive(1'b1, WR, 8'h40, 16'hAAAA, 1'b1, 1'b0, 8'h40, 16'h0);
    drive(1'b1, RD, 8'h41, 16'h0, 1'b1, 1'b1, 8'h41, 16'h5555);
    drive(1'b1, WR, 8'h44, 16'h0102, 1'b1, 1'b1, 8'h45, 16'h0304);
    drive(1'b1, RD, 8'h45, 16'h0, 1'b1, 1'b0, 8'h44, 16'h0);
    drive(1'b1, RD, 8'h40, 16'h0, 1'b1, 1'b0, 8'h41, 16'h0);

    // Port B against a DEC/INC write-back edge.
    drive(1'b1, INC, 8'h50, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0);
    drive(1'b0, RD, 8'h00, 16'h0, 1'b1, 1'b1, 8'h50, 16'h7777);
    chk("wb_coll", 32'(b_coll), 32'd1);
    drive(1'b1, DEC, 8'h12, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0);
    drive(1'b0, RD, 8'h00, 16'h0, 1'b1, 1'b0, 8'h12, 16'h0);
    chk("wb_rd_old", 32'(b_rdata), 32'h0000FFFF);
    drive(1'b1, RD, 8'h50, 16'h0, 1'b1, 1'b0, 8'h12, 16'h0);
    chk("wb_word_a", 32'(a_rdata), 32'h0001);
    chk("wb_word_b", 32'(b_rdata), 32'h0000FFFE);

`ifdef INVRAM_PARITY_EN
    drive(1'b0, RD, 8'h00, 16'h0, 1'b1, 1'b1, 8'h05, 16'h1234);
    dut.mem[5][16] = ~dut.mem[5][16];
    drive(1'b0, RD, 8'h00, 16'h0, 1'b1, 1'b0, 8'h05, 16'h0);
    chk("par_err_b", 32'(par_err[1]), 32'd1);
`endif

    // Reset in the middle of a clear: the clear restarts from address 0.
    idle(1);
    rst_n = 1'b0; in_rst = 1'b1;
    idle(2);
    rst_n = 1'b1; in_rst = 1'b0; clr_end = cyc + 256; r2 = cyc;
    model_zero();
    while (cyc < r2 + 100) @(negedge clk);
    rst_n = 1'b0; in_rst = 1'b1;
    idle(3);
    rst_n = 1'b1; in_rst = 1'b0; clr_end = cyc + 256;
    a_req = 1'b1; a_op = WR; a_addr = 8'h60; a_wdata = 16'hBEEF;
    b_req = 1'b1; b_we = 1'b1; b_addr = 8'h61; b_wdata = 16'hCAFE;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 20) begin a_req = 1'b0; b_req = 1'b0; end
    end while (busy && n < 1000);
    chk("busy_len_restart", 32'(n), 32'd256);
    drive(1'b1, RD, 8'h61, 16'h0, 1'b1, 1'b0, 8'h60, 16'h0);
    chk("busy_req_a", 32'(a_rdata), 32'd0);
    chk("busy_req_b", 32'(b_rdata), 32'd0);
    drive(1'b1, RD, 8'h10, 16'h0, 1'b1, 1'b0, 8'h30, 16'h0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
